axi_loopback_top: RTL and testbench

- Self-contained AXI4 loopback subsystem: an internal traffic-generating master (instance u_axi_mst) is wired to an internal memory-backed slave (instance u_axi_slv).
- Master repeatedly writes one INCR burst of a known address-derived pattern, then reads the same burst back.
- Slave self-checks every read beat against the golden pattern and raises a sticky error flag, visible hierarchically as u_axi_slv.rd_data_err.
- Used as a standalone smoke-test top; no external AXI ports.

---
 rtl/axi_loopback_top.sv | 373 +++++++++++++++++++++++++++++++++++++
 tb/tb_axi_loopback_top.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_loopback_top.sv
// AXI4 loopback smoke-test subsystem: a pattern-writing/reading master wired to a
// self-checking memory slave. Optional macro AXI_ERR_INJECT_EN corrupts one write beat.

module axi_mst #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 12,
  parameter int          BURST_LEN = 4,
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                aw_valid_o,
  output logic [ADDR_W-1:0]   aw_addr_o,
  output logic [7:0]          aw_len_o,
  output logic [2:0]          aw_size_o,
  output logic [1:0]          aw_burst_o,
  output logic [3:0]          aw_id_o,
  input  logic                aw_ready_i,
  output logic                w_valid_o,
  output logic [DATA_W-1:0]   w_data_o,
  output logic [DATA_W/8-1:0] w_strb_o,
  output logic                w_last_o,
  input  logic                w_ready_i,
  input  logic                b_valid_i,
  input  logic [1:0]          b_resp_i,
  output logic                b_ready_o,
  output logic                ar_valid_o,
  output logic [ADDR_W-1:0]   ar_addr_o,
  output logic [7:0]          ar_len_o,
  output logic [2:0]          ar_size_o,
  output logic [1:0]          ar_burst_o,
  output logic [3:0]          ar_id_o,
  input  logic                ar_ready_i,
  input  logic                r_valid_i,
  input  logic [DATA_W-1:0]   r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_last_i,
  output logic                r_ready_o,
  output logic [15:0]         txn_cnt_o,
  output logic [2:0]          state_o
);
  localparam int BYTE_SH     = $clog2(DATA_W/8);
  localparam int IDX_W       = $clog2(MEM_DEPTH);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
  localparam int MEM_BYTES   = MEM_DEPTH * DATA_W / 8;

  typedef enum logic [2:0] {M_IDLE, M_AW, M_W, M_B, M_AR, M_R} mst_state_e;

  mst_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [15:0]         txn_cnt_q, txn_cnt_d;
  logic [ADDR_W:0]     nxt_addr;
  logic [IDX_W-1:0]    w_idx;
  logic                last_beat;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = a >> BYTE_SH;
    return IDX_W'(w % ADDR_W'(MEM_DEPTH));
  endfunction

  assign last_beat = (beat_q == BEAT_W'(BURST_LEN-1));
  assign w_idx     = word_idx(cur_addr_q) + IDX_W'(beat_q);
  assign nxt_addr  = {1'b0, cur_addr_q} + (ADDR_W+1)'(BURST_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= M_IDLE;
      cur_addr_q <= '0;
      beat_q     <= '0;
      txn_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beat_q     <= beat_d;
      txn_cnt_q  <= txn_cnt_d;
    end
  end

  // Each state owns exactly one channel, so its VALID/READY alone decides the handshake.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beat_d     = beat_q;
    txn_cnt_d  = txn_cnt_q;
    case (state_q)
      M_IDLE: begin
        state_d = M_AW;
        beat_d  = '0;
      end
      M_AW: if (aw_ready_i) state_d = M_W;
      M_W: if (w_ready_i) begin
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          beat_d  = '0;
          state_d = M_B;
        end
      end
      M_B: if (b_valid_i) state_d = M_AR;
      M_AR: if (ar_ready_i) begin
        state_d = M_R;
        beat_d  = '0;
      end
      M_R: if (r_valid_i) begin
        beat_d = beat_q + BEAT_W'(1);
        if (r_last_i) begin
          state_d    = M_IDLE;
          beat_d     = '0;
          txn_cnt_d  = txn_cnt_q + 16'd1;
          cur_addr_d = (nxt_addr >= (ADDR_W+1)'(MEM_BYTES)) ? '0 : nxt_addr[ADDR_W-1:0];
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    b_ready_o  = 1'b0;
    ar_valid_o = 1'b0;
    r_ready_o  = 1'b0;
    w_last_o   = 1'b0;
    w_data_o   = DATA_W'(SEED) ^ DATA_W'(w_idx);
`ifdef AXI_ERR_INJECT_EN
    if (txn_cnt_q == 16'd3 && beat_q == '0) w_data_o[0] = ~w_data_o[0];
`endif
    if (!rst) begin
      case (state_q)
        M_AW: aw_valid_o = 1'b1;
        M_W: begin
          w_valid_o = 1'b1;
          w_last_o  = last_beat;
        end
        M_B:  b_ready_o  = 1'b1;
        M_AR: ar_valid_o = 1'b1;
        M_R:  r_ready_o  = 1'b1;
        default: ;
      endcase
    end
  end

  assign aw_addr_o  = cur_addr_q;
  assign ar_addr_o  = cur_addr_q;
  assign aw_len_o   = 8'(BURST_LEN-1);
  assign ar_len_o   = 8'(BURST_LEN-1);
  assign aw_size_o  = 3'(BYTE_SH);
  assign ar_size_o  = 3'(BYTE_SH);
  assign aw_burst_o = 2'b01;
  assign ar_burst_o = 2'b01;
  assign aw_id_o    = '0;
  assign ar_id_o    = '0;
  assign w_strb_o   = '1;
  assign txn_cnt_o  = txn_cnt_q;
  assign state_o    = state_q;

  logic unused_mst;
  assign unused_mst = ^{b_resp_i, r_resp_i, r_data_i};
endmodule

module axi_slv #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 12,
  parameter int          BURST_LEN = 4,
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic [2:0]          aw_size_i,
  input  logic [1:0]          aw_burst_i,
  input  logic [3:0]          aw_id_i,
  output logic                aw_ready_o,
  input  logic                w_valid_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  output logic                w_ready_o,
  output logic                b_valid_o,
  output logic [1:0]          b_resp_o,
  input  logic                b_ready_i,
  input  logic                ar_valid_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  input  logic [7:0]          ar_len_i,
  input  logic [2:0]          ar_size_i,
  input  logic [1:0]          ar_burst_i,
  input  logic [3:0]          ar_id_i,
  output logic                ar_ready_o,
  output logic                r_valid_o,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_last_o,
  input  logic                r_ready_i,
  output logic                rd_data_err_o,
  output logic [1:0]          state_o
);
  localparam int BYTE_SH = $clog2(DATA_W/8);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_W, S_B, S_R} slv_state_e;

  slv_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               rd_data_err_q, rd_data_err_d;
  logic               rd_data_err;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = a >> BYTE_SH;
    return IDX_W'(w % ADDR_W'(MEM_DEPTH));
  endfunction

  assign rd_word     = mem[idx_q];
  assign rd_data_err = rd_data_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      beat_q        <= '0;
      rd_data_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      beat_q        <= beat_d;
      rd_data_err_q <= rd_data_err_d;
    end
  end

  // Storage has no reset; contents are only read after the master has written them.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_W && w_valid_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (w_strb_i[b]) mem[idx_q][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    beat_d        = beat_q;
    rd_data_err_d = rd_data_err_q;
    case (state_q)
      S_IDLE: begin
        if (aw_valid_i) begin
          idx_d   = word_idx(aw_addr_i);
          state_d = S_W;
        end else if (ar_valid_i) begin
          idx_d   = word_idx(ar_addr_i);
          beat_d  = '0;
          state_d = S_R;
        end
      end
      S_W: if (w_valid_i) begin
        idx_d = idx_q + IDX_W'(1);
        if (w_last_i) state_d = S_B;
      end
      S_B: if (b_ready_i) state_d = S_IDLE;
      S_R: if (r_ready_i) begin
        idx_d  = idx_q + IDX_W'(1);
        beat_d = beat_q + BEAT_W'(1);
        if (rd_word != (DATA_W'(SEED) ^ DATA_W'(idx_q))) rd_data_err_d = 1'b1;
        if (beat_q == BEAT_W'(BURST_LEN-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          aw_ready_o = 1'b1;
          ar_ready_o = !aw_valid_i;
        end
        S_W: w_ready_o = 1'b1;
        S_B: b_valid_o = 1'b1;
        S_R: begin
          r_valid_o = 1'b1;
          r_last_o  = (beat_q == BEAT_W'(BURST_LEN-1));
        end
        default: ;
      endcase
    end
  end

  assign r_data_o      = rd_word;
  assign b_resp_o      = 2'b00;
  assign r_resp_o      = 2'b00;
  assign rd_data_err_o = rd_data_err;
  assign state_o       = state_q;

  logic unused_slv;
  assign unused_slv = ^{aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
                        ar_len_i, ar_size_i, ar_burst_i, ar_id_i};
endmodule

module axi_loopback_top #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 12,
  parameter int          BURST_LEN = 4,
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_data_err,
  output logic [15:0] txn_cnt
);
  logic                aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic                b_valid, b_ready, ar_valid, ar_ready;
  logic                r_valid, r_ready, r_last;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [7:0]          aw_len, ar_len;
  logic [2:0]          aw_size, ar_size;
  logic [1:0]          aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]          aw_id, ar_id;
  logic [DATA_W-1:0]   w_data, r_data;
  logic [DATA_W/8-1:0] w_strb;
  logic [2:0]          mst_state;
  logic [1:0]          slv_state;

  axi_mst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
            .MEM_DEPTH(MEM_DEPTH), .SEED(SEED)) u_axi_mst (
    .clk(clk), .rst(rst),
    .aw_valid_o(aw_valid), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
    .aw_burst_o(aw_burst), .aw_id_o(aw_id), .aw_ready_i(aw_ready),
    .w_valid_o(w_valid), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
    .w_ready_i(w_ready),
    .b_valid_i(b_valid), .b_resp_i(b_resp), .b_ready_o(b_ready),
    .ar_valid_o(ar_valid), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size),
    .ar_burst_o(ar_burst), .ar_id_o(ar_id), .ar_ready_i(ar_ready),
    .r_valid_i(r_valid), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
    .r_ready_o(r_ready),
    .txn_cnt_o(txn_cnt), .state_o(mst_state)
  );

  axi_slv #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
            .MEM_DEPTH(MEM_DEPTH), .SEED(SEED)) u_axi_slv (
    .clk(clk), .rst(rst),
    .aw_valid_i(aw_valid), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_id_i(aw_id), .aw_ready_o(aw_ready),
    .w_valid_i(w_valid), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .w_ready_o(w_ready),
    .b_valid_o(b_valid), .b_resp_o(b_resp), .b_ready_i(b_ready),
    .ar_valid_i(ar_valid), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_burst_i(ar_burst), .ar_id_i(ar_id), .ar_ready_o(ar_ready),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_ready_i(r_ready),
    .rd_data_err_o(rd_data_err), .state_o(slv_state)
  );

  // FSM state taps are kept for hierarchical probing only.
  logic unused_dbg;
  assign unused_dbg = ^{mst_state, slv_state};
endmodule

// File: tb/tb_axi_loopback_top.sv
// Self-checking bench for axi_loopback_top: bus-level reference model of the
// pattern traffic, randomized mid-burst resets, optional AXI_ERR_INJECT_EN mode.

module tb_axi_loopback_top;
  localparam logic [31:0] SEED        = 32'hA5A5_0000;
  localparam int          BURST_LEN   = 4;
  localparam int          BURST_BYTES = 16;
  localparam int          MEM_BYTES   = 1024;
  localparam int          BUDGET      = 20;
  localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;
`ifdef AXI_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_data_err;
  logic [15:0] txn_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          err_exp  = 1'b0;

  always #5 clk = ~clk;

  axi_loopback_top dut (
    .clk(clk), .rst(rst), .rd_data_err(rd_data_err), .txn_cnt(txn_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] hs_bus();
    return {dut.aw_valid, dut.aw_ready, dut.w_valid, dut.w_ready, dut.b_valid,
            dut.b_ready, dut.ar_valid, dut.ar_ready, dut.r_valid, dut.r_ready};
  endfunction

  function automatic bit vld(input int ch);
    case (ch)
      CH_AW:   return dut.aw_valid;
      CH_W:    return dut.w_valid;
      CH_B:    return dut.b_valid;
      CH_AR:   return dut.ar_valid;
      default: return dut.r_valid;
    endcase
  endfunction

  function automatic bit hs(input int ch);
    case (ch)
      CH_AW:   return dut.aw_valid && dut.aw_ready;
      CH_W:    return dut.w_valid && dut.w_ready;
      CH_B:    return dut.b_valid && dut.b_ready;
      CH_AR:   return dut.ar_valid && dut.ar_ready;
      default: return dut.r_valid && dut.r_ready;
    endcase
  endfunction

  // Waits (bounded) for a handshake; a VALID may stall at most one cycle before READY.
  task automatic wait_hs(input int ch, input string tag);
    int cyc   = 0;
    int stall = 0;
    while (!hs(ch) && cyc < BUDGET) begin
      if (vld(ch)) stall++;
      step();
      cyc++;
    end
    chk({"hs_", tag}, 32'(hs(ch) && stall <= 1), 32'd1);
  endtask

  // One write burst + read-back burst, n = pairs completed since reset.
  task automatic do_pair(input int n);
    int          addr;
    int          base;
    logic [31:0] d;
    logic [31:0] e;
    addr = (n * BURST_BYTES) % MEM_BYTES;
    base = addr / 4;

    wait_hs(CH_AW, "aw");
    chk("aw_addr", 32'(dut.aw_addr), 32'(addr));
    chk("aw_len", 32'(dut.aw_len), 32'(BURST_LEN - 1));
    chk("aw_size_burst_id", 32'({dut.aw_size, dut.aw_burst, dut.aw_id}), 32'({3'd2, 2'b01, 4'd0}));
    chk("aw_w_overlap", 32'(dut.w_valid), 32'd0);
    step();

    for (int k = 0; k < BURST_LEN; k++) begin
      d = SEED ^ 32'(base + k);
      if (INJ && n == 3 && k == 0) d[0] = ~d[0];
      exp_q.push_back(d);
      wait_hs(CH_W, "w");
      chk("w_data", dut.w_data, d);
      chk("w_last", 32'(dut.w_last), 32'(k == BURST_LEN - 1));
      chk("w_strb", 32'(dut.w_strb), 32'hF);
      step();
    end

    wait_hs(CH_B, "b");
    chk("b_resp", 32'(dut.b_resp), 32'd0);
    step();

    wait_hs(CH_AR, "ar");
    chk("ar_addr", 32'(dut.ar_addr), 32'(addr));
    chk("ar_len", 32'(dut.ar_len), 32'(BURST_LEN - 1));
    step();

    for (int k = 0; k < BURST_LEN; k++) begin
      wait_hs(CH_R, "r");
      e = exp_q.pop_front();
      chk("r_data", dut.r_data, e);
      chk("r_last", 32'(dut.r_last), 32'(k == BURST_LEN - 1));
      chk("r_resp", 32'(dut.r_resp), 32'd0);
      if (e != (SEED ^ 32'(base + k))) err_exp = 1'b1;
      step();
      chk("rd_data_err", 32'(rd_data_err), 32'(err_exp));
    end
    chk("txn_cnt", 32'(txn_cnt), 32'((n + 1) & 16'hFFFF));
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_hs_signals"}, 32'(hs_bus()), 32'd0);
    chk({tag, "_rd_data_err"}, 32'(rd_data_err), 32'd0);
    chk({tag, "_txn_cnt"}, 32'(txn_cnt), 32'd0);
  endtask

  initial begin
    int nb;
    int rc;
    int np;

    // Reset for one clock, then release; AW must follow one cycle later.
    rst = 1'b1;
    step();
    check_in_reset("reset");
    rst = 1'b0;
    chk("aw_before_release_edge", 32'(dut.aw_valid), 32'd0);
    step();
    chk("aw_one_cycle_after_release", 32'(dut.aw_valid), 32'd1);

    // Long run: covers the address wrap at pair 64.
    for (int n = 0; n < 80; n++) do_pair(n);
    chk("err_hier_alias", 32'(dut.u_axi_slv.rd_data_err), 32'(rd_data_err));

    // Randomized resets in the middle of a write burst.
    repeat (4) begin
      nb = $urandom_range(0, BURST_LEN - 1);
      wait_hs(CH_AW, "aw_pre_rst");
      step();
      for (int k = 0; k < nb; k++) begin
        wait_hs(CH_W, "w_pre_rst");
        step();
      end
      rst = 1'b1;
      #1;
      chk("valids_drop_on_rst", 32'(hs_bus()), 32'd0);
      rc = $urandom_range(1, 3);
      repeat (rc) step();
      check_in_reset("mid_rst");
      rst = 1'b0;
      exp_q.delete();
      err_exp = 1'b0;
      np = $urandom_range(2, 6);
      for (int n = 0; n < np; n++) do_pair(n);
    end
    chk("err_hier_alias_end", 32'(dut.u_axi_slv.rd_data_err), 32'(rd_data_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
